// File: rtl/mul_out_fifo_bf16.sv
// Output buffer for the bf16 multiplier pipe.
// Captures every strobed product into a first-word-fall-through FIFO and
// replays it over a stb/ack handshake. The pipe cannot be stalled, so a push
// into a full FIFO is dropped. Drops are recorded in a sticky flag and a
// saturating counter.
module mul_out_fifo_bf16 #(
    parameter int DW        = 16,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              input_z,
    input  logic                       input_z_stb,
    output logic [DW-1:0]              output_z,
    output logic                       output_z_stb,
    input  logic                       output_z_ack,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    input  logic                       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign not_empty = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));
    assign pop       = not_empty & output_z_ack;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = input_z_stb & (~full | pop);
    assign drop      = input_z_stb & full & ~pop;

    // Next-state for pointers, occupancy and overflow bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear must still be recorded.
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr)                  drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr_q] <= input_z;
    end

    // Head word is forced to zero when empty so stale entries never leak out.
    assign output_z     = not_empty ? mem[rd_ptr_q] : '0;
    assign output_z_stb = not_empty;
    assign almost_full  = (level_q >= LW'(AFULL_LVL));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_mul_out_fifo_bf16.sv
// Directed bench for mul_out_fifo_bf16 with a reference queue model.
module tb_mul_out_fifo_bf16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] input_z;
    logic        input_z_stb;
    logic [15:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    logic        almost_full;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] sb [$];
    logic        m_ovf  = 1'b0;
    int          m_drop = 0;

    always #5 clk = ~clk;

    mul_out_fifo_bf16 #(.DW(16), .DEPTH(8), .AFULL_LVL(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_z      (input_z),
        .input_z_stb  (input_z_stb),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .ovf_clr      (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs, update the model, check post-edge state.
    task automatic step(input logic zs, input logic [15:0] z, input logic ack,
                        input logic clr, input logic rb);
        logic exp_stb;
        logic was_full;
        logic do_pop;
        logic [15:0] e;
        rst          = rb;
        input_z_stb  = zs;
        input_z      = z;
        output_z_ack = ack;
        ovf_clr      = clr;
        if (rb) begin
            exp_stb  = (sb.size() != 0);
            was_full = (sb.size() == 8);
            chk("stb", output_z_stb, exp_stb);
            chk("afull", almost_full, sb.size() >= 4);
            do_pop = exp_stb && ack;
            if (do_pop) begin
                e = sb.pop_front();
                chk("data", output_z, e);
            end
            if (zs && (!was_full || do_pop)) sb.push_back(z);
            if (zs && was_full && !do_pop) begin
                m_ovf  = 1'b1;
                m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end else begin
            sb.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(posedge clk);
        #1;
        chk("level", level, sb.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    initial begin
        rst = 1'b0; input_z_stb = 1'b0; input_z = '0; output_z_ack = 1'b0; ovf_clr = 1'b0;
        #1;

        // Reset held 3 cycles while pushes are offered.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        chk("rst_stb", output_z_stb, 1'b0);
        chk("rst_z", output_z, 16'h0000);
        chk("rst_lvl", level, 4'd0);

        // Pass-through with ack held high.
        step(1'b1, 16'h3F80, 1'b1, 1'b0, 1'b1);
        chk("pt_head", output_z, 16'h3F80);
        chk("pt_lvl1", level <= 4'd1, 1'b1);
        step(1'b1, 16'h4000, 1'b1, 1'b0, 1'b1);
        chk("pt_lvl2", level <= 4'd1, 1'b1);
        step(1'b1, 16'hC040, 1'b1, 1'b0, 1'b1);
        chk("pt_lvl3", level <= 4'd1, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("pt_empty", output_z_stb, 1'b0);

        // Stall: fill to 8 with ack low.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
            chk("stall_afull", almost_full, i >= 4);
        end
        chk("stall_full", level, 4'd8);

        // Overflow while full.
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_cnt", drop_cnt, 8'd2);
        chk("ovf_head", output_z, 16'h0001);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("clr_flag", overflow, 1'b0);
        chk("clr_cnt", drop_cnt, 8'd0);

        // Drop coincident with clear: drop wins.
        step(1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b1);
        chk("dropclr_flag", overflow, 1'b1);
        chk("dropclr_cnt", drop_cnt, 8'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Push and pop together at full.
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        chk("fpp_lvl", level, 4'd8);
        chk("fpp_ovf", overflow, 1'b0);

        // Drain: 0002..0008 then 1234, then ack on empty is ignored.
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("drain_stb", output_z_stb, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("empty_ack_lvl", level, 4'd0);

        // Mid-operation reset during a push.
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b1);
        chk("mid_lvl5", level, 4'd5);
        step(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_lvl", level, 4'd0);
        chk("mid_rst_stb", output_z_stb, 1'b0);
        step(1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
        chk("mid_head", output_z, 16'h5555);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Drop counter saturation.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        chk("sat_cnt", drop_cnt, 8'd255);
        for (int i = 0; i < 9; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
